// File: rtl/fifo_datapath.sv
// fifo_datapath: registered state, 8-entry storage, pointers, count and status flags of the FIFO
module fifo_datapath #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            next_state,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [2:0]            state,
    output logic [3:0]            data_count,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err
);

    typedef enum logic [2:0] {
        INIT     = 3'b000,
        NO_OP    = 3'b001,
        WRITE    = 3'b010,
        WR_ERROR = 3'b011,
        READ     = 3'b100,
        RD_ERROR = 3'b101
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            head_q, head_d;
    logic [2:0]            tail_q, tail_d;
    logic [3:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] mem_q [8];
    logic                  wr_en;

    // Decode the requested operation; a write when full or a read when empty is demoted to its error state
    always_comb begin
        state_d = NO_OP;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        dout_d  = dout_q;
        wr_en   = 1'b0;
        case (next_state)
            INIT:     state_d = INIT;
            NO_OP:    state_d = NO_OP;
            WR_ERROR: state_d = WR_ERROR;
            RD_ERROR: state_d = RD_ERROR;
            WRITE: begin
                if (count_q == 4'd8) begin
                    state_d = WR_ERROR;
                end else begin
                    state_d = WRITE;
                    wr_en   = 1'b1;
                    tail_d  = tail_q + 3'd1;
                    count_d = count_q + 4'd1;
                end
            end
            READ: begin
                if (count_q == 4'd0) begin
                    state_d = RD_ERROR;
                end else begin
                    state_d = READ;
                    dout_d  = mem_q[head_q];
                    head_d  = head_q + 3'd1;
                    count_d = count_q - 4'd1;
                end
            end
            default:  state_d = NO_OP;
        endcase
    end

    // Control registers: state, pointers, count and read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            head_q  <= 3'd0;
            tail_q  <= 3'd0;
            count_q <= 4'd0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    // Storage is not reset; only entries between head and tail are meaningful
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) mem_q[tail_q] <= din;
    end

    assign state      = state_q;
    assign data_count = count_q;
    assign dout       = dout_q;
    assign full       = count_q == 4'd8;
    assign empty      = count_q == 4'd0;
    assign wr_ack     = state_q == WRITE;
    assign wr_err     = state_q == WR_ERROR;
    assign rd_ack     = state_q == READ;
    assign rd_err     = state_q == RD_ERROR;

endmodule

// File: tb/tb_fifo_datapath.sv
// tb_fifo_datapath: scoreboard bench driving directed next_state/din vectors into fifo_datapath
module tb_fifo_datapath;

    localparam logic [2:0] S_INIT = 3'b000;
    localparam logic [2:0] S_NOOP = 3'b001;
    localparam logic [2:0] S_WR   = 3'b010;
    localparam logic [2:0] S_WERR = 3'b011;
    localparam logic [2:0] S_RD   = 3'b100;
    localparam logic [2:0] S_RERR = 3'b101;

    typedef struct {
        logic [2:0]  st;
        logic [3:0]  cnt;
        logic [31:0] dout;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  next_state;
    logic [31:0] din;
    logic [2:0]  state;
    logic [3:0]  data_count;
    logic [31:0] dout;
    logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;
    bit   done = 1'b0;

    fifo_datapath #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .next_state(next_state), .din(din),
        .state(state), .data_count(data_count), .dout(dout),
        .full(full), .empty(empty), .wr_ack(wr_ack), .wr_err(wr_err),
        .rd_ack(rd_ack), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check(input exp_t e);
        logic [5:0] req_flags;
        req_flags = {e.cnt == 4'd8, e.cnt == 4'd0, e.st == S_WR, e.st == S_WERR, e.st == S_RD, e.st == S_RERR};
        cmp({e.tag, " state"}, {29'd0, state}, {29'd0, e.st});
        cmp({e.tag, " count"}, {28'd0, data_count}, {28'd0, e.cnt});
        cmp({e.tag, " dout"}, dout, e.dout);
        cmp({e.tag, " flags"}, {26'd0, full, empty, wr_ack, wr_err, rd_ack, rd_err}, {26'd0, req_flags});
    endtask

    // Drive one cycle, then queue what the DUT must show after that edge
    task automatic step(input logic [2:0] ns, input logic [31:0] d, input logic [2:0] st,
                        input logic [3:0] cnt, input logic [31:0] dv, input string tag);
        exp_t e;
        next_state = ns;
        din = d;
        @(posedge clk);
        #1;
        e.st = st; e.cnt = cnt; e.dout = dv; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: compare against queued expectations on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(e);
            end
        end
    end

    initial begin
        exp_t r;
        reset_n = 1'b0;
        next_state = S_NOOP;
        din = '0;
        r.st = S_INIT; r.cnt = 4'd0; r.dout = 32'd0; r.tag = "reset";
        repeat (2) @(negedge clk);
        check(r);
        reset_n = 1'b1;

        step(S_WR, 32'h1, S_WR, 4'd1, 32'd0, "burst");
        step(S_WR, 32'h2, S_WR, 4'd2, 32'd0, "burst");
        step(S_WR, 32'h3, S_WR, 4'd3, 32'd0, "burst");
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        r.tag = "mid_reset";
        check(r);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 1; i <= 8; i++)
            step(S_WR, 32'h11 * i, S_WR, 4'(i), 32'd0, "fill");
        step(S_WERR, 32'h0, S_WERR, 4'd8, 32'd0, "wr_error");
        step(S_WR, 32'hDEAD, S_WERR, 4'd8, 32'd0, "guard_wr_full");

        for (int i = 1; i <= 8; i++)
            step(S_RD, 32'h0, S_RD, 4'(8 - i), 32'h11 * i, "drain");
        step(S_RERR, 32'h0, S_RERR, 4'd0, 32'h88, "rd_error");
        step(S_RD, 32'h0, S_RERR, 4'd0, 32'h88, "guard_rd_empty");
        step(3'b110, 32'h77, S_NOOP, 4'd0, 32'h88, "illegal_110");
        step(3'b111, 32'h77, S_NOOP, 4'd0, 32'h88, "illegal_111");

        for (int i = 0; i < 6; i++)
            step(S_WR, 32'h100 + i, S_WR, 4'(i + 1), 32'h88, "wrap_w6");
        for (int i = 0; i < 6; i++)
            step(S_RD, 32'h0, S_RD, 4'(5 - i), 32'h100 + i, "wrap_r6");
        for (int i = 0; i < 5; i++)
            step(S_WR, 32'h200 + i, S_WR, 4'(i + 1), 32'h105, "wrap_w5");
        for (int i = 0; i < 5; i++)
            step(S_RD, 32'h0, S_RD, 4'(4 - i), 32'h200 + i, "wrap_r5");

        step(S_WR, 32'hA5, S_WR, 4'd1, 32'h204, "ilv_write");
        step(S_NOOP, 32'h0, S_NOOP, 4'd1, 32'h204, "ilv_noop");
        step(S_RD, 32'h0, S_RD, 4'd0, 32'hA5, "ilv_read");
        step(S_WR, 32'h5A, S_WR, 4'd1, 32'hA5, "ilv_write2");
        step(S_NOOP, 32'h0, S_NOOP, 4'd1, 32'hA5, "ilv_noop2");
        step(S_RD, 32'h0, S_RD, 4'd0, 32'h5A, "ilv_read2");
        step(S_INIT, 32'h0, S_INIT, 4'd0, 32'h5A, "init_hold");

        repeat (3) @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain_queue: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
